// File: rtl/strassen_tile_mac_if.sv
// ----------------------------------------------------------------------------
// strassen_tile_mac_if
// Bus bundle between the Strassen tile MAC, the matrix fetch logic and the
// result writer.
//   req_*  : fetch request (valid/ready), tile row/col and inner index k
//   rsp_*  : fetch response, four A and four B elements, index 0 first
//   out_*  : result stream (valid/ready), element row/col and signed data
// Modports: master = MAC side, slave = memory/sink side.
// ----------------------------------------------------------------------------
interface strassen_tile_mac_if #(
    parameter int MAX_N = 32,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int IW    = $clog2(MAX_N)
);
    logic                    req_valid;
    logic                    req_ready;
    logic [IW-1:0]           req_row;
    logic [IW-1:0]           req_col;
    logic [IW-1:0]           req_k;
    logic                    rsp_valid;
    logic [3:0][DW-1:0]      rsp_a;
    logic [3:0][DW-1:0]      rsp_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [IW-1:0]           out_row;
    logic [IW-1:0]           out_col;
    logic signed [ACC_W-1:0] out_data;

    modport master (
        output req_valid, req_row, req_col, req_k,
        input  req_ready,
        input  rsp_valid, rsp_a, rsp_b,
        output out_valid, out_row, out_col, out_data,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_row, req_col, req_k,
        output req_ready,
        output rsp_valid, rsp_a, rsp_b,
        input  out_valid, out_row, out_col, out_data,
        output out_ready
    );
endinterface

// File: rtl/strassen_tile_mac.sv
// ----------------------------------------------------------------------------
// strassen_tile_mac
// Computes C = A x B for a run-time square size dim (even, 2..MAX_N), one 2x2
// output tile at a time, stepping the inner dimension by 2 and applying the
// 7-multiply Strassen kernel per step.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   start_in, dim_in   : start pulse and matrix dimension (sampled on start)
//   busy, done, err    : run status; err pulses with done on a rejected dim
//   bus (master)       : fetch request/response and result stream
// ----------------------------------------------------------------------------
module strassen_tile_mac #(
    parameter int MAX_N = 32,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int IW    = $clog2(MAX_N)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic [IW:0]         dim_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    strassen_tile_mac_if.master bus
);
    localparam int SW = DW + 1;      // sum/difference width
    localparam int PW = 2 * DW + 2;  // product width

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_MAC, S_EMIT} state_e;

    state_e                  state_q, state_d;
    logic [IW:0]             dim_q, dim_d;
    logic [IW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic [1:0]              beat_q, beat_d;
    logic [3:0][DW-1:0]      a_q, a_d, b_q, b_d;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic                    done_q, done_d, err_q, err_d;

    function automatic logic signed [SW-1:0] sx(input logic [DW-1:0] v);
        return SW'($signed(v));
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [SW-1:0] x,
                                                 input logic signed [SW-1:0] y);
        return PW'(x) * PW'(y);
    endfunction

    // Strassen kernel on the registered operand tile
    logic signed [SW-1:0]    a11, a12, a21, a22, b11, b12, b21, b22;
    logic signed [PW-1:0]    m1, m2, m3, m4, m5, m6, m7;
    logic signed [ACC_W-1:0] e1, e2, e3, e4, e5, e6, e7;

    assign a11 = sx(a_q[0]);
    assign a12 = sx(a_q[1]);
    assign a21 = sx(a_q[2]);
    assign a22 = sx(a_q[3]);
    assign b11 = sx(b_q[0]);
    assign b12 = sx(b_q[1]);
    assign b21 = sx(b_q[2]);
    assign b22 = sx(b_q[3]);

    assign m1 = mul(a11 + a22, b11 + b22);
    assign m2 = mul(a21 + a22, b11);
    assign m3 = mul(a11, b12 - b22);
    assign m4 = mul(a22, b21 - b11);
    assign m5 = mul(a11 + a12, b22);
    assign m6 = mul(a21 - a11, b11 + b12);
    assign m7 = mul(a12 - a22, b21 + b22);

    assign e1 = ACC_W'(m1);
    assign e2 = ACC_W'(m2);
    assign e3 = ACC_W'(m3);
    assign e4 = ACC_W'(m4);
    assign e5 = ACC_W'(m5);
    assign e6 = ACC_W'(m6);
    assign e7 = ACC_W'(m7);

    // One bit of headroom so index+2 never wraps before the compare
    logic dim_ok, k_more, j_more, i_more;
    assign dim_ok = !dim_in[0] && (dim_in >= (IW+1)'(2)) && (dim_in <= (IW+1)'(MAX_N));
    assign k_more = ({1'b0, k_q} + (IW+1)'(2)) < dim_q;
    assign j_more = ({1'b0, j_q} + (IW+1)'(2)) < dim_q;
    assign i_more = ({1'b0, i_q} + (IW+1)'(2)) < dim_q;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            dim_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // NOTE: the accumulators are four plain flops, not a RAM, so they
            // take the async reset like any other state.
            for (int n = 0; n < 4; n++) acc_q[n] <= '0;
        end else begin
            state_q <= state_d;
            dim_q   <= dim_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int n = 0; n < 4; n++) acc_q[n] <= acc_d[n];
        end
    end

    // Next-state and datapath
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d = state_q;
        dim_d   = dim_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        for (int n = 0; n < 4; n++) acc_d[n] = acc_q[n];

        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (dim_ok) begin
                        dim_d   = dim_in;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        beat_d  = '0;
                        for (int n = 0; n < 4; n++) acc_d[n] = '0;
                        state_d = S_REQ;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rsp_valid) begin
                    a_d     = bus.rsp_a;
                    b_d     = bus.rsp_b;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d[0] = acc_q[0] + e1 + e4 - e5 + e7;
                acc_d[1] = acc_q[1] + e3 + e5;
                acc_d[2] = acc_q[2] + e2 + e4;
                acc_d[3] = acc_q[3] + e1 - e2 + e3 + e6;
                if (k_more) begin
                    k_d     = k_q + IW'(2);
                    state_d = S_REQ;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        for (int n = 0; n < 4; n++) acc_d[n] = '0;
                        k_d = '0;
                        if (j_more) begin
                            j_d = j_q + IW'(2);
                        end else begin
                            j_d = '0;
                            if (i_more) i_d = i_q + IW'(2);
                        end
                        if (!j_more && !i_more) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy          = (state_q != S_IDLE);
        done          = done_q;
        err           = err_q;
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_k     = '0;
        bus.out_valid = 1'b0;
        bus.out_row   = '0;
        bus.out_col   = '0;
        bus.out_data  = '0;
        if (state_q == S_REQ) begin
            bus.req_valid = 1'b1;
            bus.req_row   = i_q;
            bus.req_col   = j_q;
            bus.req_k     = k_q;
        end
        if (state_q == S_EMIT) begin
            // Beat order C11, C12, C21, C22: beat[1] selects row, beat[0] column
            bus.out_valid = 1'b1;
            bus.out_row   = i_q + IW'(beat_q[1]);
            bus.out_col   = j_q + IW'(beat_q[0]);
            bus.out_data  = acc_q[beat_q];
        end
    end
endmodule

// File: tb/tb_strassen_tile_mac.sv
// ----------------------------------------------------------------------------
// tb_strassen_tile_mac
// Directed bench for strassen_tile_mac: a memory model answers fetch requests,
// a sink consumes results against a queue of expected beats computed with a
// plain matrix product.
// ----------------------------------------------------------------------------
module tb_strassen_tile_mac;
    localparam int MAX_N = 32;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int IW    = $clog2(MAX_N);
    localparam int BUDGET = 5000;

    typedef struct {
        int                      row;
        int                      col;
        logic signed [ACC_W-1:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [IW:0] dim_in;
    logic        busy, done, err;

    strassen_tile_mac_if #(.MAX_N(MAX_N), .DW(DW), .ACC_W(ACC_W), .IW(IW)) ifc ();

    strassen_tile_mac #(.MAX_N(MAX_N), .DW(DW), .ACC_W(ACC_W), .IW(IW)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start_in),
        .dim_in   (dim_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (ifc.master)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    ma [MAX_N][MAX_N];
    int    mb [MAX_N][MAX_N];
    beat_t sb_q [$];
    bit    rand_mode = 1'b0;
    int    stale_cnt = 0;
    int    req_cnt = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int            pend_cnt = 0;
    int            pend_r, pend_c, pend_k;
    logic          req_stall = 1'b0;
    logic [IW-1:0] prev_row, prev_col, prev_k;

    initial begin
        ifc.req_ready = 1'b0;
        ifc.rsp_valid = 1'b0;
        ifc.rsp_a     = '0;
        ifc.rsp_b     = '0;
        forever begin
            @(negedge clk);
            ifc.rsp_valid = 1'b0;
            if (rst) begin
                pend_cnt      = 0;
                req_stall     = 1'b0;
                ifc.req_ready = 1'b0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        ifc.rsp_valid = 1'b1;
                        ifc.rsp_a[0] = 8'(ma[pend_r][pend_k]);
                        ifc.rsp_a[1] = 8'(ma[pend_r][pend_k+1]);
                        ifc.rsp_a[2] = 8'(ma[pend_r+1][pend_k]);
                        ifc.rsp_a[3] = 8'(ma[pend_r+1][pend_k+1]);
                        ifc.rsp_b[0] = 8'(mb[pend_k][pend_c]);
                        ifc.rsp_b[1] = 8'(mb[pend_k][pend_c+1]);
                        ifc.rsp_b[2] = 8'(mb[pend_k+1][pend_c]);
                        ifc.rsp_b[3] = 8'(mb[pend_k+1][pend_c+1]);
                    end
                end else if (stale_cnt > 0) begin
                    stale_cnt--;
                    ifc.rsp_valid = 1'b1;
                    ifc.rsp_a     = {4{8'h7f}};
                    ifc.rsp_b     = {4{8'h7f}};
                end
                if (req_stall) begin
                    check("req_valid_held", ifc.req_valid, 1);
                    check("req_row_held", ifc.req_row, prev_row);
                    check("req_col_held", ifc.req_col, prev_col);
                    check("req_k_held", ifc.req_k, prev_k);
                end
                ifc.req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ifc.req_valid && ifc.req_ready) begin
                    req_cnt++;
                    pend_r   = int'(ifc.req_row);
                    pend_c   = int'(ifc.req_col);
                    pend_k   = int'(ifc.req_k);
                    pend_cnt = rand_mode ? int'($urandom_range(1, 5)) : 1;
                end
                req_stall = ifc.req_valid && !ifc.req_ready;
                prev_row  = ifc.req_row;
                prev_col  = ifc.req_col;
                prev_k    = ifc.req_k;
            end
        end
    end

    // ---------------- result sink ----------------
    logic                    out_stall = 1'b0;
    logic [IW-1:0]           prev_orow, prev_ocol;
    logic signed [ACC_W-1:0] prev_odata;

    initial begin
        beat_t e;
        ifc.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_stall     = 1'b0;
                ifc.out_ready = 1'b0;
            end else begin
                if (out_stall) begin
                    check("out_valid_held", ifc.out_valid, 1);
                    check("out_row_held", ifc.out_row, prev_orow);
                    check("out_col_held", ifc.out_col, prev_ocol);
                    check("out_data_held", ifc.out_data, prev_odata);
                end
                ifc.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ifc.out_valid && ifc.out_ready) begin
                    check("beat_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("out_row", ifc.out_row, e.row);
                        check("out_col", ifc.out_col, e.col);
                        check("out_data", ifc.out_data, e.data);
                    end
                end
                out_stall  = ifc.out_valid && !ifc.out_ready;
                prev_orow  = ifc.out_row;
                prev_ocol  = ifc.out_col;
                prev_odata = ifc.out_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_expected(input int dim);
        beat_t  e;
        longint sum;
        for (int ti = 0; ti < dim; ti += 2)
            for (int tj = 0; tj < dim; tj += 2)
                for (int b = 0; b < 4; b++) begin
                    e.row = ti + b / 2;
                    e.col = tj + b % 2;
                    sum = 0;
                    for (int x = 0; x < dim; x++) sum += longint'(ma[e.row][x]) * longint'(mb[x][e.col]);
                    e.data = ACC_W'(sum);
                    sb_q.push_back(e);
                end
    endtask

    task automatic start_pulse(input int dim);
        @(negedge clk);
        start_in = 1'b1;
        dim_in   = (IW+1)'(dim);
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic run_mult(input int dim, input bit spam);
        bit seen = 1'b0;
        int tiles = (dim / 2) * (dim / 2);
        push_expected(dim);
        req_cnt = 0;
        start_pulse(dim);
        check("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < BUDGET && !seen; cyc++) begin
            if (spam) begin
                start_in = (cyc % 7 == 3);
                dim_in   = (IW+1)'(2);
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start_in = 1'b0;
        check("done_seen", seen, 1);
        check("err_on_done", err, 0);
        check("busy_on_done", busy, 0);
        check("beats_left", sb_q.size(), 0);
        check("req_count", req_cnt, tiles * (dim / 2));
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        sb_q.delete();
    endtask

    task automatic bad_start(input int dim);
        start_pulse(dim);
        check("bad_done", done, 1);
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_req_valid", ifc.req_valid, 0);
        @(negedge clk);
        check("bad_done_pulse", done, 0);
        check("bad_err_pulse", err, 0);
        check("bad_busy_after", busy, 0);
        check("bad_req_after", ifc.req_valid, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_req_valid"}, ifc.req_valid, 0);
        check({tag, "_req_row"}, ifc.req_row, 0);
        check({tag, "_req_col"}, ifc.req_col, 0);
        check({tag, "_req_k"}, ifc.req_k, 0);
        check({tag, "_out_valid"}, ifc.out_valid, 0);
        check({tag, "_out_row"}, ifc.out_row, 0);
        check({tag, "_out_col"}, ifc.out_col, 0);
        check({tag, "_out_data"}, ifc.out_data, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        rst      = 1'b1;
        start_in = 1'b0;
        dim_in   = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 2x2 textbook product
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        run_mult(2, 1'b0);

        // identity x ramp
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = 4 * r + c;
            end
        run_mult(4, 1'b0);

        // most-negative operands, then mixed-sign extremes
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ma[r][c] = -128;
                mb[r][c] = -128;
            end
        run_mult(2, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) mb[r][c] = 127;
        run_mult(2, 1'b0);

        // random data with stalls, latency and ignored start pulses
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                ma[r][c] = int'($urandom_range(0, 255)) - 128;
                mb[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        rand_mode = 1'b1;
        run_mult(4, 1'b1);
        run_mult(6, 1'b0);
        rand_mode = 1'b0;

        // rejected dimensions
        bad_start(3);
        bad_start(0);
        bad_start(MAX_N + 2);

        // reset in the middle of EMIT
        push_expected(4);
        start_pulse(4);
        seen = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !seen; cyc++) begin
            @(negedge clk);
            if (ifc.out_valid) seen = 1'b1;
        end
        check("emit_reached", seen, 1);
        repeat (2) @(negedge clk);
        check("mid_emit_valid", ifc.out_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // stale response while idle must not start anything
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ma[r][c] = int'($urandom_range(0, 255)) - 128;
                mb[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        @(negedge clk);
        stale_cnt = 1;
        repeat (3) @(negedge clk);
        check("stale_busy", busy, 0);
        check("stale_req", ifc.req_valid, 0);
        run_mult(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
